// File: rtl/wb_commit_arbiter_if.sv
// Writeback-lane inputs and register-file write ports bundled for wb_commit_arbiter.
// The master side drives results and flush; the slave side (the arbiter) drives ready and writes.
interface wb_commit_arbiter_if #(
  parameter int LANES  = 2,
  parameter int WPORTS = 1,
  parameter int XLEN   = 32,
  parameter int TAG_W  = 3
);
  logic [LANES-1:0]       in_valid;
  logic [LANES-1:0]       in_ready;
  logic [LANES*TAG_W-1:0] in_tag;
  logic [LANES-1:0]       in_regwrite;
  logic [LANES*5-1:0]     in_rd;
  logic [LANES*XLEN-1:0]  in_data;
  logic                   flush;
  logic [TAG_W-1:0]       flush_tag;
  logic [WPORTS-1:0]      wr_en;
  logic [WPORTS*5-1:0]    wr_addr;
  logic [WPORTS*XLEN-1:0] wr_data;
  logic [2:0]             retire_cnt;
  logic [TAG_W-1:0]       next_tag_o;
  logic                   err_dup;

  modport master (
    output in_valid, in_tag, in_regwrite, in_rd, in_data, flush, flush_tag,
    input  in_ready, wr_en, wr_addr, wr_data, retire_cnt, next_tag_o, err_dup
  );

  modport slave (
    input  in_valid, in_tag, in_regwrite, in_rd, in_data, flush, flush_tag,
    output in_ready, wr_en, wr_addr, wr_data, retire_cnt, next_tag_o, err_dup
  );
endinterface

// File: rtl/wb_commit_arbiter.sv
// In-order writeback arbiter: holds one result per lane and retires the oldest contiguous
// tag run onto WPORTS register-file write ports, keeping only the youngest write per rd.
module wb_commit_arbiter #(
  parameter int LANES  = 2,
  parameter int WPORTS = 1,
  parameter int XLEN   = 32,
  parameter int TAG_W  = 3
) (
  input logic                CLK,
  input logic                RST,
  wb_commit_arbiter_if.slave bus
);
  localparam int LIDX_W = (LANES > 1) ? $clog2(LANES) : 1;
  localparam int CNT_W  = 3;

  logic [LANES-1:0]       holdValid_q;
  logic [TAG_W-1:0]       holdTag_q [LANES];
  logic [LANES-1:0]       holdRegwrite_q;
  logic [4:0]             holdRd_q [LANES];
  logic [XLEN-1:0]        holdData_q [LANES];
  logic [TAG_W-1:0]       nextTag_q;
  logic [WPORTS-1:0]      wrEn_q, wrEn_d;
  logic [WPORTS*5-1:0]    wrAddr_q, wrAddr_d;
  logic [WPORTS*XLEN-1:0] wrData_q, wrData_d;
  logic [CNT_W-1:0]       retireCnt_q, retireN;
  logic                   errDup_q, dupNow;

  logic [LANES-1:0]  candFound, candWriter, retiring, inReady;
  logic [LIDX_W-1:0] candLane [LANES];
  logic [4:0]        candRd [LANES];
  logic [XLEN-1:0]   candData [LANES];

  // A writer at slot k survives unless a younger slot inside the first n slots writes the same rd.
  function automatic logic survives(input int k, input int n, input logic [LANES-1:0] writers,
                                    input logic [4:0] rds [LANES]);
    logic keep;
    keep = writers[k];
    for (int j = 0; j < LANES; j++)
      if (j > k && j < n && writers[j] && rds[j] == rds[k]) keep = 1'b0;
    return keep;
  endfunction

  always_comb begin : candidateSelect
    for (int k = 0; k < LANES; k++) begin
      candFound[k] = 1'b0;
      candLane[k]  = '0;
      for (int l = LANES - 1; l >= 0; l--)
        if (holdValid_q[l] && holdTag_q[l] == nextTag_q + TAG_W'(k)) begin
          candFound[k] = 1'b1;
          candLane[k]  = LIDX_W'(l);
        end
      candRd[k]     = holdRd_q[candLane[k]];
      candData[k]   = holdData_q[candLane[k]];
      candWriter[k] = candFound[k] & holdRegwrite_q[candLane[k]] & (candRd[k] != 5'd0);
    end
  end

  // Surviving-writer count never shrinks as the prefix grows, so the largest fitting prefix wins.
  always_comb begin : prefixSelect
    logic             runOk;
    logic [CNT_W-1:0] writeCnt;
    retireN  = '0;
    runOk    = 1'b1;
    writeCnt = '0;
    for (int p = 1; p <= LANES; p++) begin
      runOk    = runOk & candFound[p-1];
      writeCnt = '0;
      for (int k = 0; k < p; k++)
        if (survives(k, p, candWriter, candRd)) writeCnt = writeCnt + CNT_W'(1);
      if (runOk && writeCnt <= CNT_W'(WPORTS)) retireN = CNT_W'(p);
    end
  end

  always_comb begin : portAssign
    int portIdx;
    portIdx  = 0;
    wrEn_d   = '0;
    wrAddr_d = '0;
    wrData_d = '0;
    retiring = '0;
    for (int k = 0; k < LANES; k++) begin
      if (CNT_W'(k) < retireN) begin
        retiring[candLane[k]] = 1'b1;
        if (survives(k, int'(retireN), candWriter, candRd) && portIdx < WPORTS) begin
          wrEn_d[portIdx]                 = 1'b1;
          wrAddr_d[portIdx*5 +: 5]        = candRd[k];
          wrData_d[portIdx*XLEN +: XLEN]  = candData[k];
          portIdx                         = portIdx + 1;
        end
      end
    end
  end

  always_comb begin : dupDetect
    dupNow = 1'b0;
    for (int i = 0; i < LANES; i++)
      for (int j = i + 1; j < LANES; j++)
        if (holdValid_q[i] && holdValid_q[j] && holdTag_q[i] == holdTag_q[j]) dupNow = 1'b1;
  end

  assign inReady = {LANES{~bus.flush}} & (~holdValid_q | retiring);

  // Flush wins over both retirement and acceptance in the same cycle.
  always_ff @(posedge CLK or posedge RST) begin : stateUpdate
    if (RST) begin
      holdValid_q    <= '0;
      holdRegwrite_q <= '0;
      for (int l = 0; l < LANES; l++) begin
        holdTag_q[l]  <= '0;
        holdRd_q[l]   <= '0;
        holdData_q[l] <= '0;
      end
      nextTag_q   <= '0;
      wrEn_q      <= '0;
      wrAddr_q    <= '0;
      wrData_q    <= '0;
      retireCnt_q <= '0;
      errDup_q    <= 1'b0;
    end else begin
      errDup_q <= errDup_q | dupNow;
      if (bus.flush) begin
        holdValid_q <= '0;
        nextTag_q   <= bus.flush_tag;
        wrEn_q      <= '0;
        retireCnt_q <= '0;
      end else begin
        for (int l = 0; l < LANES; l++) begin
          if (inReady[l] && bus.in_valid[l]) begin
            holdValid_q[l]    <= 1'b1;
            holdTag_q[l]      <= bus.in_tag[l*TAG_W +: TAG_W];
            holdRegwrite_q[l] <= bus.in_regwrite[l];
            holdRd_q[l]       <= bus.in_rd[l*5 +: 5];
            holdData_q[l]     <= bus.in_data[l*XLEN +: XLEN];
          end else if (retiring[l]) begin
            holdValid_q[l] <= 1'b0;
          end
        end
        nextTag_q   <= nextTag_q + TAG_W'(retireN);
        wrEn_q      <= wrEn_d;
        wrAddr_q    <= wrAddr_d;
        wrData_q    <= wrData_d;
        retireCnt_q <= retireN;
      end
    end
  end

  assign bus.in_ready   = inReady;
  assign bus.wr_en      = wrEn_q;
  assign bus.wr_addr    = wrAddr_q;
  assign bus.wr_data    = wrData_q;
  assign bus.retire_cnt = retireCnt_q;
  assign bus.next_tag_o = nextTag_q;
  assign bus.err_dup    = errDup_q;
endmodule
